regfile_param: RTL and testbench

- Parametrised next-generation register file for the CPU datapath.
- Configurable width, depth and read-port count.
- Two write ports with fixed priority and write-to-read bypass, so the pipeline needs no separate forwarding for same-cycle writeback.
- Multi-cycle background clear sweep with a busy flag, plus a debug tap that drives the board LEDs from a selectable register.

---
 rtl/regfile_pkg.sv | 20 ++
 rtl/regfile_clear_fsm.sv | 57 +++++
 rtl/regfile_param.sv | 97 +++++++++
 tb/tb_regfile_param.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and defaults for the parametrised register file.
// Pure declarations: no logic, no latency, no flow control.
// Holds the sweep-FSM state encoding and the fixed write-port count.
package regfile_pkg;

    localparam int DEF_DATA_W   = 32;
    localparam int DEF_ADDR_W   = 5;
    localparam int DEF_NUM_RD   = 2;
    localparam int DEF_ZERO_REG = 1;
    localparam int DEF_DBG_REG  = 1;
    localparam int DEF_DBG_W    = 16;

    localparam int NUM_WR = 2;

    typedef enum logic {
        IDLE     = 1'b0,
        CLEARING = 1'b1
    } clr_state_t;

endpackage

// File: rtl/regfile_clear_fsm.sv
// Background clear sweep: zeroes one entry per cycle, 2**ADDR_W cycles total.
// busy rises one cycle after ctrl_clear; a clear request while sweeping is ignored.
// No backpressure: writers must stall on busy, reset aborts the sweep.
module regfile_clear_fsm
    import regfile_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clock,
    input  logic              ctrl_reset,
    input  logic              ctrl_clear,
    output logic              busy,
    output logic              clr_en,
    output logic [ADDR_W-1:0] clr_addr
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    clr_state_t        r_state;
    logic [ADDR_W-1:0] r_ptr;
    logic              r_busy;

    always_ff @(posedge clock) begin
        if (ctrl_reset) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (ctrl_clear) begin
                        r_state <= CLEARING;
                        r_busy  <= 1'b1;
                        r_ptr   <= '0;
                    end
                end
                CLEARING: begin
                    // pointer wraps back to 0 naturally on the final step
                    r_ptr <= r_ptr + 1'b1;
                    if (r_ptr == LAST_ADDR) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = r_busy;
    assign clr_en   = (r_state == CLEARING);
    assign clr_addr = r_ptr;

endmodule

// File: rtl/regfile_param.sv
// Parametrised register file: two prioritised write ports, NUM_RD bypassed read ports, LED tap.
// Reads are combinational (zero latency); writes commit on the rising edge.
// No backpressure: writes during a clear sweep are dropped, callers stall on busy.
module regfile_param
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NUM_RD   = DEF_NUM_RD,
    parameter int ZERO_REG = DEF_ZERO_REG,
    parameter int DBG_REG  = DEF_DBG_REG,
    parameter int DBG_W    = DEF_DBG_W
) (
    input  logic                     clock,
    input  logic                     ctrl_reset,
    input  logic                     ctrl_clear,
    input  logic [NUM_WR-1:0]        ctrl_writeEnable,
    input  logic [NUM_WR*ADDR_W-1:0] ctrl_writeReg,
    input  logic [NUM_WR*DATA_W-1:0] data_writeReg,
    input  logic [NUM_RD*ADDR_W-1:0] ctrl_readReg,
    output logic [NUM_RD*DATA_W-1:0] data_readReg,
    output logic                     busy,
    output logic [DBG_W-1:0]         LED
);

    localparam int                DEPTH   = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] DBG_IDX = DBG_REG[ADDR_W-1:0];

    logic [DATA_W-1:0] r_regs [DEPTH];

    logic              w_clr_en;
    logic [ADDR_W-1:0] w_clr_addr;
    logic [ADDR_W-1:0] w_wa     [NUM_WR];
    logic [DATA_W-1:0] w_wd     [NUM_WR];
    logic              w_byp_ok [NUM_WR];
    logic              w_wr_ok  [NUM_WR];

    regfile_clear_fsm #(
        .ADDR_W (ADDR_W)
    ) u_clear_fsm (
        .clock      (clock),
        .ctrl_reset (ctrl_reset),
        .ctrl_clear (ctrl_clear),
        .busy       (busy),
        .clr_en     (w_clr_en),
        .clr_addr   (w_clr_addr)
    );

    for (genvar p = 0; p < NUM_WR; p++) begin : g_wr
        assign w_wa[p]     = ctrl_writeReg[p*ADDR_W +: ADDR_W];
        assign w_wd[p]     = data_writeReg[p*DATA_W +: DATA_W];
        assign w_byp_ok[p] = ctrl_writeEnable[p] && !w_clr_en;
        assign w_wr_ok[p]  = w_byp_ok[p] && !((ZERO_REG != 0) && (w_wa[p] == '0));
    end

    // Higher port index is applied last, so port 1 wins a same-address collision.
    always_ff @(posedge clock) begin
        if (ctrl_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_clr_en) begin
            r_regs[w_clr_addr] <= '0;
        end else begin
            for (int p = 0; p < NUM_WR; p++) begin
                if (w_wr_ok[p]) begin
                    r_regs[w_wa[p]] <= w_wd[p];
                end
            end
        end
    end

    for (genvar r = 0; r < NUM_RD; r++) begin : g_rd
        logic [ADDR_W-1:0] w_ra;
        logic [DATA_W-1:0] w_rd;

        assign w_ra = ctrl_readReg[r*ADDR_W +: ADDR_W];

        always_comb begin
            w_rd = r_regs[w_ra];
            for (int p = 0; p < NUM_WR; p++) begin
                if (w_byp_ok[p] && (w_wa[p] == w_ra)) begin
                    w_rd = w_wd[p];
                end
            end
            // hardwired zero overrides the bypass as well
            if ((ZERO_REG != 0) && (w_ra == '0)) begin
                w_rd = '0;
            end
        end

        assign data_readReg[r*DATA_W +: DATA_W] = w_rd;
    end

    assign LED = r_regs[DBG_IDX][DBG_W-1:0];

endmodule

// File: tb/tb_regfile_param.sv
// Bench for regfile_param: default instance against an array model, plus a small 8-entry instance.
module tb_regfile_param;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int NR    = 2;
    localparam int DEPTH = 32;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic             rst, clr;
    logic [1:0]       we;
    logic [2*AW-1:0]  wa;
    logic [2*DW-1:0]  wd;
    logic [NR*AW-1:0] ra;
    wire  [NR*DW-1:0] rd;
    wire              busy;
    wire  [15:0]      led;

    logic             rst_b, clr_b;
    logic [1:0]       we_b;
    logic [5:0]       wa_b;
    logic [63:0]      wd_b;
    logic [8:0]       ra_b;
    wire  [95:0]      rd_b;
    wire              busy_b;
    wire  [15:0]      led_b;

    regfile_param dut_a (
        .clock            (clock),
        .ctrl_reset       (rst),
        .ctrl_clear       (clr),
        .ctrl_writeEnable (we),
        .ctrl_writeReg    (wa),
        .data_writeReg    (wd),
        .ctrl_readReg     (ra),
        .data_readReg     (rd),
        .busy             (busy),
        .LED              (led)
    );

    regfile_param #(.ADDR_W(3), .NUM_RD(3), .ZERO_REG(0)) dut_b (
        .clock            (clock),
        .ctrl_reset       (rst_b),
        .ctrl_clear       (clr_b),
        .ctrl_writeEnable (we_b),
        .ctrl_writeReg    (wa_b),
        .data_writeReg    (wd_b),
        .ctrl_readReg     (ra_b),
        .data_readReg     (rd_b),
        .busy             (busy_b),
        .LED              (led_b)
    );

    int total = 0;
    int bad   = 0;

    logic [31:0] m [DEPTH];
    int          busy_left = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
        if (busy_left == 0 && we[1] && wa[9:5] == a) return wd[63:32];
        if (busy_left == 0 && we[0] && wa[4:0] == a) return wd[31:0];
        return m[a];
    endfunction

    task automatic idle_in();
        rst = 1'b0; clr = 1'b0; we = 2'b00; wa = '0; wd = '0; ra = '0;
    endtask

    task automatic idle_in_b();
        rst_b = 1'b0; clr_b = 1'b0; we_b = 2'b00; wa_b = '0; wd_b = '0; ra_b = '0;
    endtask

    // Check current outputs against the model, advance the model, then take one edge.
    task automatic tick_a();
        #1;
        if (!rst) begin
            for (int p = 0; p < NR; p++)
                chk($sformatf("rd%0d_a%0d", p, ra[p*AW +: AW]), rd[p*DW +: DW], exp_rd(ra[p*AW +: AW]));
            chk("busy", busy, (busy_left > 0));
            chk("led", led, m[1][15:0]);
        end
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) m[i] = 32'h0;
            busy_left = 0;
        end else if (busy_left > 0) begin
            m[DEPTH - busy_left] = 32'h0;
            busy_left--;
        end else begin
            if (clr) busy_left = DEPTH;
            if (we[0] && wa[4:0] != 5'd0) m[wa[4:0]] = wd[31:0];
            if (we[1] && wa[9:5] != 5'd0) m[wa[9:5]] = wd[63:32];
        end
        @(posedge clock);
        #1;
    endtask

    task automatic tick_b();
        @(posedge clock);
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        idle_in();
        idle_in_b();
        for (int i = 0; i < DEPTH; i++) m[i] = 32'h0;
        @(posedge clock);
        #1;

        // reset, then sweep every address on both read ports
        rst = 1'b1;
        tick_a();
        idle_in();
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_led", led, 16'h0);
        for (int a = 0; a < 16; a++) begin
            ra = {5'(a + 16), 5'(a)};
            #1;
            chk("rst_rd0", rd[31:0], 32'h0);
            chk("rst_rd1", rd[63:32], 32'h0);
            tick_a();
        end

        // bypass then stored value
        we = 2'b01; wa[4:0] = 5'd5; wd[31:0] = 32'hDEADBEEF; ra[9:5] = 5'd5;
        #1;
        chk("byp_r5", rd[63:32], 32'hDEADBEEF);
        tick_a();
        we = 2'b00;
        #1;
        chk("stored_r5", rd[63:32], 32'hDEADBEEF);
        tick_a();

        // same-address collision: port 1 wins
        we = 2'b11; wa = {5'd7, 5'd7}; wd = {32'h22222222, 32'h11111111}; ra[4:0] = 5'd7;
        #1;
        chk("coll_byp_r7", rd[31:0], 32'h22222222);
        tick_a();
        we = 2'b00;
        #1;
        chk("coll_r7", rd[31:0], 32'h22222222);
        tick_a();

        // writes to r0 are discarded
        we = 2'b01; wa[4:0] = 5'd0; wd[31:0] = 32'hFFFFFFFF; ra = {5'd0, 5'd0};
        #1;
        chk("r0_byp", rd[31:0], 32'h0);
        tick_a();
        we = 2'b00;
        #1;
        chk("r0_stored", rd[63:32], 32'h0);
        tick_a();

        // LED tap follows r1 one cycle after the write
        we = 2'b01; wa[4:0] = 5'd1; wd[31:0] = 32'h0001ABCD;
        tick_a();
        we = 2'b00;
        #1;
        chk("led_abcd", led, 16'hABCD);

        // full clear sweep with dropped write and ignored re-clear
        clr = 1'b1;
        tick_a();
        clr = 1'b0;
        chk("sweep_busy_rise", busy, 1'b1);
        n = 0;
        while (busy && n < 40) begin
            we  = (n == 3) ? 2'b01 : 2'b00;
            wa[4:0] = 5'd9; wd[31:0] = 32'h0000_1234;
            clr = (n == 5);
            ra  = {5'(n), 5'd9};
            tick_a();
            n++;
        end
        idle_in();
        chk("sweep_len", 32'(n), 32'd32);
        for (int a = 0; a < 16; a++) begin
            ra = {5'(a + 16), 5'(a)};
            #1;
            chk("post_clr_rd0", rd[31:0], 32'h0);
            chk("post_clr_rd1", rd[63:32], 32'h0);
            tick_a();
        end
        chk("post_clr_led", led, 16'h0);

        // randomized traffic against the model
        for (int c = 0; c < 400; c++) begin
            we = 2'($urandom);
            wa = 10'($urandom);
            wd = {$urandom, $urandom};
            ra = 10'($urandom);
            if ($urandom_range(3) == 0) ra[4:0] = wa[4:0];
            if ($urandom_range(3) == 0) ra[9:5] = wa[9:5];
            clr = ($urandom_range(59) == 0);
            rst = ($urandom_range(199) == 0);
            tick_a();
        end
        idle_in();

        // fill some entries, then abort a sweep with reset at sweep cycle 10
        n = 0;
        while (busy && n < 40) begin
            tick_a();
            n++;
        end
        chk("idle_before_abort", busy, 1'b0);
        for (int a = 1; a < 32; a += 3) begin
            we = 2'b01; wa[4:0] = 5'(a); wd[31:0] = 32'hA500_0000 | 32'(a);
            tick_a();
        end
        idle_in();
        clr = 1'b1;
        tick_a();
        clr = 1'b0;
        for (int k = 0; k < 10; k++) tick_a();
        chk("abort_busy_pre", busy, 1'b1);
        rst = 1'b1;
        tick_a();
        rst = 1'b0;
        #1;
        chk("abort_busy", busy, 1'b0);
        for (int a = 0; a < 16; a++) begin
            ra = {5'(a + 16), 5'(a)};
            #1;
            chk("abort_rd0", rd[31:0], 32'h0);
            chk("abort_rd1", rd[63:32], 32'h0);
            tick_a();
        end
        we = 2'b01; wa[4:0] = 5'd3; wd[31:0] = 32'h5;
        tick_a();
        we = 2'b00; ra[4:0] = 5'd3;
        #1;
        chk("after_abort_r3", rd[31:0], 32'h5);
        tick_a();

        // 8-entry, three read ports, entry 0 writable
        rst_b = 1'b1;
        tick_b();
        rst_b = 1'b0;
        we_b = 2'b01; wa_b[2:0] = 3'd0; wd_b[31:0] = 32'h42; ra_b = 9'd0;
        #1;
        for (int p = 0; p < 3; p++)
            chk($sformatf("b_byp_r0_p%0d", p), rd_b[p*32 +: 32], 32'h42);
        tick_b();
        we_b = 2'b00;
        #1;
        for (int p = 0; p < 3; p++)
            chk($sformatf("b_r0_p%0d", p), rd_b[p*32 +: 32], 32'h42);
        clr_b = 1'b1;
        tick_b();
        clr_b = 1'b0;
        n = 0;
        while (busy_b && n < 20) begin
            tick_b();
            n++;
        end
        chk("b_sweep_len", 32'(n), 32'd8);
        #1;
        chk("b_r0_cleared", rd_b[31:0], 32'h0);
        idle_in_b();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
